image_double: RTL and testbench
===============================

Name: image_double

Overview:
- Nearest-neighbour 2x upsampler: the inverse of the pyramid half-scale stage.
- Scans a half-resolution image held in BRAM (OLD_WIDTH x OLD_HEIGHT) and emits a full-resolution raster stream (2*OLD_WIDTH x 2*OLD_HEIGHT).
- Each output beat carries pixel data, x, y and valid; this is the same stream format the pyramid/DoG stages consume.
- Sits between an octave BRAM and any stage needing a re-expanded octave.

Parameters:
- BIT_DEPTH, 8, pixel width in bits.
- OLD_WIDTH, 32, source image width in pixels; must be ≤128.
- OLD_HEIGHT, 32, source image height in pixels; must be ≤128.
- ADDR_WIDTH, 10, source BRAM address width; must be ≥ clog2(OLD_WIDTH*OLD_HEIGHT).
- BRAM_LATENCY, 2, read latency of the source BRAM in cycles; must be ≥1.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  one-cycle pulse; begins a full-frame scan.
- bram_addr_out  output  ADDR_WIDTH  source BRAM read address.
- bram_data_in  input  BIT_DEPTH  source BRAM read data, valid BRAM_LATENCY cycles after its address.
- data_out  output  BIT_DEPTH  output pixel.
- data_x_out  output  8  output pixel column, range 0..2*OLD_WIDTH-1.
- data_y_out  output  8  output pixel row, range 0..2*OLD_HEIGHT-1.
- data_valid_out  output  1  data_out, data_x_out and data_y_out are valid this cycle.
- busy_out  output  1  a scan is in progress.
- done_out  output  1  one-cycle pulse at the end of a scan.
- error_out  output  1  only present with IMAGE_DOUBLE_ERROR_EN.

Behaviour:
- Reset:
  - All outputs go to 0.
  - State goes to IDLE; x/y counters clear; in-flight pipeline valids clear.
  - Reset mid-scan abandons the scan; no done_out is produced.
- FSM states are IDLE, READ, DRAIN.
  - IDLE: start_in=1 sets busy_out=1 on the next edge and enters READ with the counters at x=0, y=0.
  - READ: each cycle issues bram_addr_out = (y>>1)*OLD_WIDTH + (x>>1) and pushes (x, y, valid=1) into a BRAM_LATENCY-deep pipeline.
  - READ counter advance: x increments; at x=2*OLD_WIDTH-1, x wraps to 0 and y increments.
  - READ exit: after issuing (2*OLD_WIDTH-1, 2*OLD_HEIGHT-1), move to DRAIN.
  - DRAIN: issues no new reads and waits for the pipeline to empty.
  - DRAIN exit: in the cycle after the final data_valid_out, pulse done_out=1, set busy_out=0 and return to IDLE.
- Output timing:
  - data_out = bram_data_in, with data_x_out and data_y_out taken from the pipeline tail.
  - The first valid output appears BRAM_LATENCY cycles after the first address is issued.
  - Throughput is 1 pixel/cycle, with no gaps within a frame.
- Totals per frame:
  - Exactly 4*OLD_WIDTH*OLD_HEIGHT valid beats per frame.
  - Total scan length, from start_in to done_out, is 4*OLD_WIDTH*OLD_HEIGHT + BRAM_LATENCY + 1 cycles.
- Arithmetic: the address product is computed at ADDR_WIDTH with no truncation for legal parameters. The x/y counters are 8 bits.
- When data_valid_out=0, data_out, data_x_out and data_y_out hold their last values; checkers must ignore them.
- start_in while busy_out=1 is ignored and the scan continues unaffected.
- start_in in the same cycle as the done_out pulse is also ignored; a new start is accepted only in IDLE.
- rst_in and start_in asserted together: reset wins.

Optional Feature:
- IMAGE_DOUBLE_ERROR_EN
- Defined:
  - error_out is a sticky flag, set on the cycle after start_in arrives while busy_out=1.
  - It is cleared only by rst_in.
  - Scan behaviour is unchanged.
- Undefined:
  - The port is absent and no logic is generated.

Decomposition:
- Shared pyramid package holds:
  - the pixel-stream coordinate width constant (8);
  - a pixel-beat struct typedef {data, x, y, valid};
  - the FSM state enum.
- Sub-module: pipe_delay, a parameterized shift register (WIDTH, DEPTH) that carries coordinate/valid bits alongside BRAM latency. It is reusable by other BRAM readers.

Test Plan:
- Basic frame:
  - Stimulus: OLD_WIDTH=2, OLD_HEIGHT=2; BRAM model holds {10,20,30,40}; pulse start_in.
  - Response: 16 beats in raster order.
  - Rows 0-1 = 10,10,20,20; rows 2-3 = 30,30,40,40.
  - Coordinates run (0,0)..(3,3); done_out pulses once; busy_out drops the same cycle.
- Latency:
  - Stimulus: BRAM_LATENCY=1, then BRAM_LATENCY=3.
  - Response: the first data_valid_out lags the first address by exactly 1 and 3 cycles respectively.
  - data_valid_out is continuous with no gaps; total scan length matches the formula.
- Default size:
  - Stimulus: 32x32 source with pixel = address mod 256.
  - Response: 4096 beats; every beat satisfies data_out == ((y>>1)*32 + (x>>1)) mod 256.
  - Last beat is (63,63).
- Start while busy:
  - Stimulus: start_in pulsed at beat 5 of a scan.
  - Response: scan unchanged, still 16 beats (2x2 case), a single done_out.
  - With IMAGE_DOUBLE_ERROR_EN, error_out=1 from the following cycle until reset.
- Reset mid-scan:
  - Stimulus: rst_in at beat 7.
  - Response: next cycle all outputs are 0, no done_out, busy_out=0.
  - A subsequent start_in produces a clean full frame from (0,0).
- Back-to-back:
  - Stimulus: start_in issued the cycle after done_out.
  - Response: the second frame is identical to the first.

Source files
------------

// File: rtl/image_double_pkg.sv
// Shared pyramid stream types: coordinate width, pixel beat, scan FSM states.
package image_double_pkg;

    localparam int COORD_W = 8;
    localparam int PIX_W   = 8;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        coord_t           x;
        coord_t           y;
        logic             valid;
    } pix_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_e;

endpackage

// File: rtl/image_double_pipe_delay.sv
// Fixed-depth shift register carrying sideband bits alongside a BRAM read.
module pipe_delay
    import image_double_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/image_double.sv
// Nearest-neighbour 2x upsampler streaming a half-res BRAM image as raster beats.
// Optional sticky error_out on start-while-busy: define IMAGE_DOUBLE_ERROR_EN.
module image_double
    import image_double_pkg::*;
#(
    parameter int BIT_DEPTH    = 8,
    parameter int OLD_WIDTH    = 32,
    parameter int OLD_HEIGHT   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    input  logic [BIT_DEPTH-1:0]  bram_data_in,
    output logic [BIT_DEPTH-1:0]  data_out,
    output logic [COORD_W-1:0]    data_x_out,
    output logic [COORD_W-1:0]    data_y_out,
    output logic                  data_valid_out,
    output logic                  busy_out,
    output logic                  done_out
`ifdef IMAGE_DOUBLE_ERROR_EN
    ,
    output logic                  error_out
`endif
);

    localparam int     PW     = 2 * COORD_W + 1;
    localparam coord_t X_LAST = coord_t'(2 * OLD_WIDTH - 1);
    localparam coord_t Y_LAST = coord_t'(2 * OLD_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] W_A = ADDR_WIDTH'(OLD_WIDTH);

    state_e state_q, state_d;
    coord_t x_q, x_d, y_q, y_d;
    logic   busy_q, busy_d, done_q, done_d;

    logic [BIT_DEPTH-1:0] data_q;
    coord_t               xh_q, yh_q;

    logic          issue;
    logic [PW-1:0] pipe_in, pipe_out;
    coord_t        tail_x, tail_y;
    logic          tail_v, last_beat;
    logic [ADDR_WIDTH-1:0] addr;

    assign issue   = (state_q == READ);
    assign pipe_in = {x_q, y_q, issue};

    pipe_delay #(
        .WIDTH(PW),
        .DEPTH(BRAM_LATENCY)
    ) u_pipe (
        .clk_i(clk_in),
        .rst_i(rst_in),
        .d_i  (pipe_in),
        .q_o  (pipe_out)
    );

    assign {tail_x, tail_y, tail_v} = pipe_out;
    assign last_beat = tail_v && tail_x == X_LAST && tail_y == Y_LAST;

    assign addr = ADDR_WIDTH'(y_q >> 1) * W_A + ADDR_WIDTH'(x_q >> 1);
    assign bram_addr_out = issue ? addr : '0;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // done_q marks the done cycle, where a start is still refused
                if (start_in && !done_q) begin
                    state_d = READ;
                    busy_d  = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            READ: begin
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                    if (y_q == Y_LAST) begin
                        y_d     = '0;
                        state_d = DRAIN;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            DRAIN: begin
                if (last_beat) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            xh_q    <= '0;
            yh_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (tail_v) begin
                data_q <= bram_data_in;
                xh_q   <= tail_x;
                yh_q   <= tail_y;
            end
        end
    end

    assign data_valid_out = tail_v;
    assign data_out       = tail_v ? bram_data_in : data_q;
    assign data_x_out     = tail_v ? tail_x : xh_q;
    assign data_y_out     = tail_v ? tail_y : yh_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;

`ifdef IMAGE_DOUBLE_ERROR_EN
    logic err_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            err_q <= 1'b0;
        end else if (start_in && busy_q) begin
            err_q <= 1'b1;
        end
    end

    assign error_out = err_q;
`endif

endmodule

// File: tb/tb_image_double.sv
// Directed bench for image_double: 2x2 frames at latencies 1/2/3 and a 32x32 frame.
module tb_image_double;
    import image_double_pkg::*;

    typedef struct {
        pix_beat_t  b;
        logic [9:0] a;
        logic       busy;
        logic       done;
        logic       err;
    } rec_t;

    logic       clk;
    logic       rst   [4];
    logic       start [4];
    logic [9:0] addr  [4];
    logic [7:0] bdat  [4];
    logic [7:0] dout  [4];
    logic [7:0] xo    [4];
    logic [7:0] yo    [4];
    logic       vo    [4];
    logic       busy  [4];
    logic       done  [4];
    logic       err   [4];

    int n_chk;
    int n_fail;

    rec_t      trace [$];
    pix_beat_t beats [$];
    pix_beat_t first [$];

    int exp2 [16] = '{10, 10, 20, 20, 10, 10, 20, 20,
                      30, 30, 40, 40, 30, 30, 40, 40};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0: 2x2 L=2, 1: 2x2 L=1, 2: 2x2 L=3, 3: 32x32 L=2
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int L = (g == 1) ? 1 : (g == 2) ? 3 : 2;
        localparam int W = (g == 3) ? 32 : 2;
        logic [9:0] ap [L];

        image_double #(
            .BIT_DEPTH   (8),
            .OLD_WIDTH   (W),
            .OLD_HEIGHT  (W),
            .ADDR_WIDTH  (10),
            .BRAM_LATENCY(L)
        ) u_dut (
            .clk_in        (clk),
            .rst_in        (rst[g]),
            .start_in      (start[g]),
            .bram_addr_out (addr[g]),
            .bram_data_in  (bdat[g]),
            .data_out      (dout[g]),
            .data_x_out    (xo[g]),
            .data_y_out    (yo[g]),
            .data_valid_out(vo[g]),
            .busy_out      (busy[g]),
            .done_out      (done[g])
`ifdef IMAGE_DOUBLE_ERROR_EN
            ,
            .error_out     (err[g])
`endif
        );

`ifndef IMAGE_DOUBLE_ERROR_EN
        assign err[g] = 1'b0;
`endif

        always @(posedge clk) begin
            ap[0] <= addr[g];
            for (int i = 1; i < L; i++) ap[i] <= ap[i-1];
        end

        assign bdat[g] = (W == 2) ? 8'((32'(ap[L-1]) + 1) * 10)
                                  : ap[L-1][7:0];
    end

    function automatic rec_t sample(input int k);
        rec_t r;
        r.b.data  = dout[k];
        r.b.x     = xo[k];
        r.b.y     = yo[k];
        r.b.valid = vo[k];
        r.a       = addr[k];
        r.busy    = busy[k];
        r.done    = done[k];
        r.err     = err[k];
        return r;
    endfunction

    // Called at a negedge; trace[j-1] holds cycle j after start is sampled.
    task automatic capture(input int k, input int maxc,
                           input int poke_start, input int poke_rst);
        trace.delete();
        start[k] = 1'b1;
        for (int j = 1; j <= maxc; j++) begin
            @(negedge clk);
            start[k] = 1'b0;
            rst[k]   = 1'b0;
            trace.push_back(sample(k));
            if (j == poke_start) start[k] = 1'b1;
            if (j == poke_rst) rst[k] = 1'b1;
            if (trace[$].done) break;
        end
    endtask

    function automatic void collect_beats();
        beats.delete();
        foreach (trace[i]) if (trace[i].b.valid) beats.push_back(trace[i].b);
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            rst[k]   = 1'b1;
            start[k] = (k == 0);
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            rst[k]   = 1'b0;
            start[k] = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            rec_t r;
            r = sample(k);
            n_chk++;
            if ({r.b, r.a, r.busy, r.done, r.err} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got v=%0b d=%0d x=%0d y=%0d a=%0d busy=%0b done=%0b err=%0b, want all 0",
                         k, r.b.valid, r.b.data, r.b.x, r.b.y, r.a, r.busy, r.done, r.err);
            end
        end
        @(negedge clk);
        n_chk++;
        if (busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_beats_start: busy got %0b want 0", busy[0]);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        capture(0, 40, 0, 0);
        collect_beats();
        n_chk++;
        if (beats.size() != 16) begin
            n_fail++;
            $display("FAIL basic_count: got %0d want 16", beats.size());
        end
        for (int i = 0; i < 16 && i < beats.size(); i++) begin
            n_chk++;
            if ({beats[i].data, beats[i].x, beats[i].y} !==
                {8'(exp2[i]), 8'(i % 4), 8'(i / 4)}) begin
                n_fail++;
                $display("FAIL basic_beat[%0d]: got d=%0d (%0d,%0d) want d=%0d (%0d,%0d)",
                         i, beats[i].data, beats[i].x, beats[i].y, exp2[i], i % 4, i / 4);
            end
        end
        for (int i = 0; i < 16 && i < trace.size(); i++) begin
            n_chk++;
            if (trace[i].a !== 10'(exp2[i] / 10 - 1)) begin
                n_fail++;
                $display("FAIL basic_addr[%0d]: got %0d want %0d", i, trace[i].a, exp2[i] / 10 - 1);
            end
        end
        n_chk++;
        if (trace.size() != 19 || trace[$].done !== 1'b1 || trace[$].busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got cycle %0d done=%0b busy=%0b want cycle 19 done=1 busy=0",
                     trace.size(), trace[$].done, trace[$].busy);
        end
        n_chk++;
        if (trace.size() < 2 || trace[trace.size()-2].busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_before_done: got 0 want 1");
        end
    endtask

    task automatic test_latency();
        for (int k = 1; k <= 2; k++) begin
            int lat;
            int fv;
            int bad;
            lat = (k == 1) ? 1 : 3;
            @(negedge clk);
            capture(k, 40, 0, 0);
            fv  = -1;
            bad = 0;
            foreach (trace[i]) if (fv < 0 && trace[i].b.valid) fv = i;
            n_chk++;
            if (trace[0].busy !== 1'b1 || fv != lat) begin
                n_fail++;
                $display("FAIL latency_first[L=%0d]: got lag %0d busy=%0b want lag %0d busy=1",
                         lat, fv, trace[0].busy, lat);
            end
            for (int i = 0; i < 16; i++) begin
                if (fv < 0 || fv + i >= trace.size()) bad++;
                else if (trace[fv+i].b.valid !== 1'b1 ||
                         trace[fv+i].b.data !== 8'(exp2[i])) bad++;
            end
            n_chk++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL latency_stream[L=%0d]: got %0d bad beats want 0", lat, bad);
            end
            n_chk++;
            if (trace.size() != 17 + lat || trace[$].done !== 1'b1) begin
                n_fail++;
                $display("FAIL latency_length[L=%0d]: got %0d want %0d", lat, trace.size(), 17 + lat);
            end
        end
    endtask

    task automatic test_default_size();
        @(negedge clk);
        capture(3, 4200, 0, 0);
        collect_beats();
        n_chk++;
        if (beats.size() != 4096) begin
            n_fail++;
            $display("FAIL big_count: got %0d want 4096", beats.size());
        end
        for (int i = 0; i < beats.size() && i < 4096; i++) begin
            logic [7:0] ex, ey, ed;
            ex = 8'(i % 64);
            ey = 8'(i / 64);
            ed = 8'((ey >> 1) * 32 + (ex >> 1));
            n_chk++;
            if ({beats[i].data, beats[i].x, beats[i].y} !== {ed, ex, ey}) begin
                n_fail++;
                $display("FAIL big_beat[%0d]: got d=%0d (%0d,%0d) want d=%0d (%0d,%0d)",
                         i, beats[i].data, beats[i].x, beats[i].y, ed, ex, ey);
            end
        end
        n_chk++;
        if (beats.size() == 0 || beats[$].x !== 8'd63 || beats[$].y !== 8'd63) begin
            n_fail++;
            $display("FAIL big_last: got (%0d,%0d) want (63,63)",
                     beats.size() ? beats[$].x : 0, beats.size() ? beats[$].y : 0);
        end
        n_chk++;
        if (trace.size() != 4099 || trace[$].done !== 1'b1) begin
            n_fail++;
            $display("FAIL big_length: got %0d want 4099", trace.size());
        end
    endtask

    task automatic test_start_busy();
        int bad;
        @(negedge clk);
        capture(0, 40, 8, 0);
        collect_beats();
        bad = (beats.size() == 16) ? 0 : 1;
        for (int i = 0; i < 16 && i < beats.size(); i++)
            if ({beats[i].data, beats[i].x, beats[i].y} !==
                {8'(exp2[i]), 8'(i % 4), 8'(i / 4)}) bad++;
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL busy_start_frame: got %0d bad beats want 0", bad);
        end
        n_chk++;
        if (trace.size() != 19 || trace[$].done !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_done: got cycle %0d want 19", trace.size());
        end
`ifdef IMAGE_DOUBLE_ERROR_EN
        n_chk++;
        if (trace[7].err !== 1'b0 || trace[8].err !== 1'b1 || trace[$].err !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_error: got %0b%0b%0b want 011",
                     trace[7].err, trace[8].err, trace[$].err);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int nd;
        int bad;
        rec_t r;
        @(negedge clk);
        capture(0, 30, 0, 10);
        r = trace[10];
        n_chk++;
        if ({r.b, r.a, r.busy, r.done, r.err} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got v=%0b d=%0d x=%0d y=%0d a=%0d busy=%0b done=%0b err=%0b, want all 0",
                     r.b.valid, r.b.data, r.b.x, r.b.y, r.a, r.busy, r.done, r.err);
        end
        nd = 0;
        foreach (trace[i]) if (trace[i].done) nd++;
        n_chk++;
        if (nd != 0 || trace.size() != 30) begin
            n_fail++;
            $display("FAIL midreset_nodone: got %0d done pulses want 0", nd);
        end
        @(negedge clk);
        capture(0, 40, 0, 0);
        collect_beats();
        bad = (beats.size() == 16) ? 0 : 1;
        for (int i = 0; i < 16 && i < beats.size(); i++)
            if ({beats[i].data, beats[i].x, beats[i].y} !==
                {8'(exp2[i]), 8'(i % 4), 8'(i / 4)}) bad++;
        n_chk++;
        if (bad != 0 || trace.size() != 19) begin
            n_fail++;
            $display("FAIL midreset_refresh: got %0d bad beats, cycle %0d want 0, 19", bad, trace.size());
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        @(negedge clk);
        capture(0, 40, 0, 0);
        collect_beats();
        first = beats;
        @(negedge clk);
        capture(0, 40, 0, 0);
        collect_beats();
        bad = (beats.size() == first.size() && beats.size() == 16) ? 0 : 1;
        for (int i = 0; i < 16 && i < beats.size() && i < first.size(); i++)
            if (beats[i] !== first[i] ||
                beats[i].data !== 8'(exp2[i])) bad++;
        n_chk++;
        if (bad != 0 || trace.size() != 19) begin
            n_fail++;
            $display("FAIL b2b_frame: got %0d bad beats, cycle %0d want 0, 19", bad, trace.size());
        end
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n_chk++;
        if (busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_start_on_done: busy got %0b want 0", busy[0]);
        end
        @(negedge clk);
        n_chk++;
        if (busy[0] !== 1'b0 || vo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_hold: busy=%0b valid=%0b want 0 0", busy[0], vo[0]);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_latency();
        test_default_size();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
